// File: rtl/mont_pow.sv
// mont_pow: left-to-right square-and-multiply modular exponentiation over one shared Montgomery REDC.
// Define MONT_POW_CONST_TIME_EN for data-independent latency (MUL after every SQ).
module mont_redc #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] MOD = 998244353,
  parameter logic [WIDTH-1:0] NPRIME = 998244351
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);
  logic [2*WIDTH-1:0] t;
  logic [2*WIDTH-1:0] mm;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] u;
  assign t = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign m = t[WIDTH-1:0] * NPRIME;
  assign mm = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, MOD};
  // low halves of t and m*MOD sum to 0 or R; they carry exactly when either is nonzero
  assign u = {1'b0, t[2*WIDTH-1:WIDTH]} + {1'b0, mm[2*WIDTH-1:WIDTH]} + {{WIDTH{1'b0}}, |mm[WIDTH-1:0]};
  assign r = WIDTH'(u >= {1'b0, MOD} ? u - {1'b0, MOD} : u);
endmodule

module mont_pow #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] MOD = 998244353,
  parameter logic [WIDTH-1:0] NPRIME = 998244351,
  parameter logic [WIDTH-1:0] R2MOD = 932051910,
  parameter logic [WIDTH-1:0] RMOD = 301989884,
  parameter int EXP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);
  localparam int IW = $clog2(EXP_W);
  typedef enum logic [2:0] {IDLE, CONV, SQ, MUL, FROM, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] base, acc, op_a, op_b, red;
  logic [EXP_W-1:0] exp;
  logic [IW-1:0] idx;
  logic last, bit_set, sq_dec;
  assign last = idx == '0;
  assign bit_set = exp[idx];
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // base holds the raw operand until CONV, then its Montgomery form
  assign op_a = state == CONV ? base : acc;
  assign op_b = state == CONV ? R2MOD :
                state == MUL  ? base :
                state == FROM ? WIDTH'(1) : acc;
`ifdef MONT_POW_CONST_TIME_EN
  assign sq_dec = 1'b0;
`else
  assign sq_dec = !bit_set && !last;
`endif
  mont_redc #(.WIDTH(WIDTH), .MOD(MOD), .NPRIME(NPRIME)) u_redc (.a(op_a), .b(op_b), .r(red));
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid && in_ready ? CONV : IDLE;
      CONV: nxt = SQ;
`ifdef MONT_POW_CONST_TIME_EN
      SQ:   nxt = MUL;
`else
      SQ:   nxt = bit_set ? MUL : last ? FROM : SQ;
`endif
      MUL:  nxt = last ? FROM : SQ;
      FROM: nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_result <= '0;
      base <= '0;
      acc <= '0;
      exp <= '0;
      idx <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          base <= in_base;
          exp <= in_exp;
          acc <= RMOD;
          idx <= IW'(EXP_W - 1);
        end
        CONV: base <= red;
        SQ: begin
          acc <= red;
          if (sq_dec) idx <= idx - 1'b1;
        end
        MUL: begin
          acc <= bit_set ? red : acc;
          if (!last) idx <= idx - 1'b1;
        end
        FROM: out_result <= red;
        default: ;
      endcase
    end
  end
endmodule
